// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial adder.
// The requester drives operands and start; the controller returns status and result.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   modport master (
      output start, a, b, c_in,
      input  busy, done, sum, carry_out
   );

   modport slave (
      input  start, a, b, c_in,
      output busy, done, sum, carry_out
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walked across WIDTH bits, LSB first.
// The ripple carry lives in a register between cycles.

// One-bit full adder cell.
module fa (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ c_in;
   assign carry = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_add_ctrl_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] a_sh_d;
   logic [WIDTH-1:0] b_sh_d;
   logic [WIDTH-1:0] acc_d;
   logic             fa_sum;
   logic             fa_carry;

   fa u_fa (
      .a     (a_sh_q[0]),
      .b     (b_sh_q[0]),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // Operands move one bit toward the adder each RUN cycle.
   always_comb begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
   end

   // New sum bit enters at the MSB so the LSB-first result lands aligned.
   generate
      if (WIDTH == 1) begin : g_w1
         assign acc_d = fa_sum;
      end else begin : g_wn
         assign acc_d = {fa_sum, acc_q[WIDTH-1:1]};
      end
   endgenerate

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh_q  <= bus.a;
                  b_sh_q  <= bus.b;
                  carry_q <= bus.c_in;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_sh_q  <= a_sh_d;
               b_sh_q  <= b_sh_d;
               acc_q   <= acc_d;
               carry_q <= fa_carry;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  sum_q   <= acc_d;
                  cout_q  <= fa_carry;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed table, hand sequences, random vs model.
// Covers WIDTH=8 and WIDTH=1 instances.
module tb_serial_add_ctrl;
   logic clk;
   logic rst8;
   logic rst1;

   int total;
   int bad;

   serial_add_ctrl_if #(.WIDTH(8)) if8 ();
   serial_add_ctrl_if #(.WIDTH(1)) if1 ();

   serial_add_ctrl #(.WIDTH(8)) u8 (
      .clk (clk),
      .rst (rst8),
      .bus (if8.slave)
   );

   serial_add_ctrl #(.WIDTH(1)) u1 (
      .clk (clk),
      .rst (rst1),
      .bus (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t tv[6];

   // last visible result of each instance, tracked by the bench
   logic [8:0] last8;
   logic [1:0] last1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] es,
                       input logic eco, input string nm);
      int k;
      int bc;
      logic stable;
      @(negedge clk);
      if8.start = 1'b1;
      if8.a     = a;
      if8.b     = b;
      if8.c_in  = ci;
      @(negedge clk);
      if8.start = 1'b0;
      if8.a     = 8'($urandom);
      if8.b     = 8'($urandom);
      if8.c_in  = 1'($urandom);
      k = 0;
      bc = 0;
      stable = 1'b1;
      while (!if8.done && k < 20) begin
         if (if8.busy) bc++;
         if ({if8.carry_out, if8.sum} !== last8) stable = 1'b0;
         @(negedge clk);
         k++;
      end
      chk({nm, ".lat"}, k, 8);
      chk({nm, ".busy"}, bc, 8);
      chk({nm, ".stable"}, 32'(stable), 1);
      chk({nm, ".sum"}, if8.sum, es);
      chk({nm, ".cout"}, if8.carry_out, eco);
      chk({nm, ".busy_at_done"}, if8.busy, 0);
      last8 = {eco, es};
      @(negedge clk);
      chk({nm, ".done_1cyc"}, if8.done, 0);
   endtask

   task automatic run1(input logic a, input logic b, input logic ci,
                       input string nm);
      logic [1:0] exp;
      int k;
      int bc;
      exp = 2'(a) + 2'(b) + 2'(ci);
      @(negedge clk);
      if1.start = 1'b1;
      if1.a     = a;
      if1.b     = b;
      if1.c_in  = ci;
      @(negedge clk);
      if1.start = 1'b0;
      k = 0;
      bc = 0;
      while (!if1.done && k < 10) begin
         if (if1.busy) bc++;
         @(negedge clk);
         k++;
      end
      chk({nm, ".lat"}, k, 1);
      chk({nm, ".busy"}, bc, 1);
      chk({nm, ".res"}, {if1.carry_out, if1.sum}, exp);
      last1 = exp;
      @(negedge clk);
      chk({nm, ".done_1cyc"}, if1.done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t, t1, t2, dn;
      logic [8:0] m;
      logic [7:0] ra, rb;
      logic rc;

      total = 0;
      bad   = 0;
      last8 = '0;
      last1 = '0;

      tv[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
      tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tv[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tv[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      tv[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

      if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0;
      rst8 = 1'b1;
      rst1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.busy", if8.busy, 0);
      chk("rst.done", if8.done, 0);
      chk("rst.res", {if8.carry_out, if8.sum}, 0);
      chk("rst1.res", {if1.busy, if1.done, if1.carry_out, if1.sum}, 0);
      rst8 = 1'b0;
      rst1 = 1'b0;

      for (int i = 0; i < 6; i++)
         run8(tv[i].a, tv[i].b, tv[i].ci, tv[i].s, tv[i].co,
              $sformatf("tv%0d", i));

      // start pulsed mid-RUN must be ignored
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'h20; if8.b = 8'h02; if8.c_in = 1'b0;
      @(negedge clk);
      dn = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 3) begin
            if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h11;
         end else begin
            if8.start = 1'b0;
         end
         @(negedge clk);
         if (if8.done) dn++;
      end
      chk("midstart.ndone", dn, 1);
      chk("midstart.res", {if8.carry_out, if8.sum}, 9'h022);
      last8 = 9'h022;

      // async reset in the middle of RUN
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.c_in = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstrun.busy_before", if8.busy, 1);
      #2 rst8 = 1'b1;
      #1;
      chk("rstrun.busy", if8.busy, 0);
      chk("rstrun.done", if8.done, 0);
      chk("rstrun.res", {if8.carry_out, if8.sum}, 0);
      @(negedge clk);
      rst8 = 1'b0;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (if8.done || if8.busy) dn++;
      end
      chk("rstrun.quiet", dn, 0);
      last8 = '0;
      run8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, "after_rst");

      // start held through DONE: back-to-back operations
      @(negedge clk);
      if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.c_in = 1'b0;
      t = 0; t1 = -1; t2 = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         t++;
         if (t1 >= 0 && t == t1 + 1) begin
            chk("b2b.nogap", if8.busy, 1);
            if8.start = 1'b0;
         end
         if (if8.done) begin
            if (t1 < 0) begin
               t1 = t;
               chk("b2b.r1", {if8.carry_out, if8.sum}, 9'h002);
               if8.a = 8'h80; if8.b = 8'h80;
            end else if (t2 < 0) begin
               t2 = t;
               chk("b2b.r2", {if8.carry_out, if8.sum}, 9'h100);
            end
         end
      end
      chk("b2b.gap", t2 - t1, 9);
      last8 = 9'h100;

      // random operands against plain integer addition
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         m  = 9'(ra) + 9'(rb) + 9'(rc);
         run8(ra, rb, rc, m[7:0], m[8], $sformatf("rnd%0d", i));
      end

      // WIDTH=1: full-adder truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         run1(v[2], v[1], v[0], $sformatf("w1_%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
